execute_flag_shadow_stack: RTL and testbench
============================================

# execute_flag_shadow_stack

Saves the execute-stage flag word when an interrupt or exception is taken, and hands it back on return. It is the producer side of the flag register's PFLAGR restore interface: it drives the 5-bit restored flag word and its one-cycle valid strobe into the execute flag register. It sits beside the execute flag register and is controlled by the exception/interrupt sequencer.

## Interface
- P_DEPTH, 4: number of shadow entries (power of two, 2..16)
- P_DEPTH_W, $clog2(P_DEPTH)+1: width of the occupancy count
- iCLOCK  in  1  core clock
- inRESET  in  1  asynchronous reset, active low
- iRESET_SYNC  in  1  synchronous soft reset, same effect as inRESET
- iCTRL_HOLD  in  1  pipeline hold; freezes all state
- iFLAG  in  5  current committed flag word from the flag register
- iFLAG_NEXT  in  5  flag word being written this cycle
- iFLAG_NEXT_VALID  in  1  the flag register commits iFLAG_NEXT at this edge
- iSAVE_REQ  in  1  push the flags (interrupt/exception entry)
- iRESTORE_REQ  in  1  pop the flags (return from interrupt)
- iFLAGR_BUSY  in  1  flag register cannot accept a restore this cycle
- oRESTORE_READY  out  1  iRESTORE_REQ will be accepted
- oPFLAGR  out  5  restored flag word
- oPFLAGR_VALID  out  1  one-cycle restore strobe
- oDEPTH  out  P_DEPTH_W  number of valid entries
- oOVERFLOW  out  1  sticky: a save was dropped because the stack was full
- oUNDERFLOW  out  1  sticky: a restore was issued while the stack was empty

## Operation
- Flag bit order is defined in the shared package: [0] ZF, [1] PF, [2] CF, [3] OF, [4] SF.
- Save value: iFLAG_NEXT when iFLAG_NEXT_VALID is high, else iFLAG. This bypass makes sure the push captures the post-update flags.
- Two-state FSM:
  - IDLE: oRESTORE_READY=1.
  - PEND: a restore has been committed but not yet delivered; oRESTORE_READY=0.
- Restore accept (iRESTORE_REQ and oRESTORE_READY, stack not empty): the top entry is copied into the output holding register and depth decrements at the same edge.
  - If iFLAGR_BUSY is low, oPFLAGR_VALID pulses on the next cycle and the FSM stays in IDLE.
  - If iFLAGR_BUSY is high, the FSM goes to PEND.
- PEND: on the first cycle with iFLAGR_BUSY low and iCTRL_HOLD low, oPFLAGR_VALID pulses and the FSM returns to IDLE.
- iRESTORE_REQ while in PEND is ignored. The caller must wait for oRESTORE_READY.
- Save while full: the entry is dropped, depth is unchanged and oOVERFLOW is set.
- Restore while empty: no pulse, no state change and oUNDERFLOW is set.
- Save and restore in the same cycle:
  - The restore reads the old top.
  - The save writes the save value into that same slot.
  - Depth is unchanged.
  - If the stack is empty, the save is performed and the restore counts as an underflow.
- Saves are accepted in both IDLE and PEND, because the popped value is already held in the output holding register.
- iCTRL_HOLD high: no push, no pop, no FSM transition. oPFLAGR_VALID is held low and any strobe is deferred to the next unheld cycle.
- Sticky flags are cleared only by reset (inRESET or iRESET_SYNC).

## Timing
- Reset values, for both inRESET low (asynchronous) and iRESET_SYNC (synchronous): all entries 0, oDEPTH=0, FSM=IDLE, oPFLAGR=5'h00, oPFLAGR_VALID=0, oOVERFLOW=0, oUNDERFLOW=0, oRESTORE_READY=1.
- Reset during PEND abandons the pending restore: no strobe is produced.
- Save latency: a save at edge N is visible in oDEPTH after edge N, and can be restored from cycle N+1 onward.
- Restore latency: 1 cycle from request to oPFLAGR_VALID when not busy. When busy, the strobe follows the cycle in which busy deasserts.
- oPFLAGR holds its value after the strobe until the next restore.
- All outputs are registered except oRESTORE_READY, which is decoded from the FSM state only (no input path).

## Structure
- Shared package execute_flag_pkg:
  - flag bit index constants (ZF_BIT … SF_BIT)
  - typedef flag_t (logic [4:0])
  - FSM enum {IDLE, PEND}
- Sub-module execute_flag_lifo: a parameterised LIFO with push, pop, simultaneous replace-top, full/empty and count.
- The top level holds the bypass mux, the FSM, the output holding register and the sticky error flags.

## Test plan
- Push then pop: save with iFLAG=5'h15, then restore with busy=0 → one cycle later oPFLAGR=5'h15, oPFLAGR_VALID=1 for exactly 1 cycle, oDEPTH back to 0.
- Bypass: save in the same cycle as iFLAG_NEXT_VALID=1 with iFLAG_NEXT=5'h0A and iFLAG=5'h1F → the later restore returns 5'h0A.
- Busy stall: restore while iFLAGR_BUSY=1 for 3 cycles → oRESTORE_READY=0; strobe appears only after busy drops; a save during the stall is accepted and the depth count is correct.
- Overflow/underflow:
  - 5 saves with P_DEPTH=4 → oDEPTH=4, oOVERFLOW=1, 4 restores return the first 4 values in LIFO order.
  - A 5th restore → no strobe, oUNDERFLOW=1.
- Simultaneous save and restore at depth 2 (top=5'h03, new save value=5'h1C) → oPFLAGR=5'h03, depth stays 2, the next restore returns 5'h1C.
- iCTRL_HOLD and reset: hold during a request → nothing changes. Assert inRESET while in PEND → all outputs return to reset values and no strobe is produced after release.

Source files
------------

// File: rtl/execute_flag_shadow_stack_pkg.sv
// Shared definitions for the execute-stage flag shadow stack: flag bit layout,
// flag word type, restore FSM encoding and the save-value bypass helper.
package execute_flag_pkg;

    localparam int ZF_BIT = 0;
    localparam int PF_BIT = 1;
    localparam int CF_BIT = 2;
    localparam int OF_BIT = 3;
    localparam int SF_BIT = 4;

    typedef logic [4:0] flag_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } fsm_state_t;

    localparam flag_t FLAG_RESET = 5'h00;

    // A flag update committing at the same edge as the save must win over the stale word.
    function automatic flag_t flag_select(input flag_t cur, input flag_t nxt, input logic nxt_valid);
        flag_t sel;
        if (nxt_valid) begin
            sel = nxt;
        end else begin
            sel = cur;
        end
        return sel;
    endfunction

endpackage

// File: rtl/execute_flag_shadow_stack_if.sv
// Control/data bundle between the exception sequencer / flag register (master)
// and the flag shadow stack (slave).
interface execute_flag_shadow_stack_if #(
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_W = $clog2(P_DEPTH) + 1
);
    import execute_flag_pkg::*;

    logic                 iCTRL_HOLD;
    flag_t                iFLAG;
    flag_t                iFLAG_NEXT;
    logic                 iFLAG_NEXT_VALID;
    logic                 iSAVE_REQ;
    logic                 iRESTORE_REQ;
    logic                 iFLAGR_BUSY;
    logic                 oRESTORE_READY;
    flag_t                oPFLAGR;
    logic                 oPFLAGR_VALID;
    logic [P_DEPTH_W-1:0] oDEPTH;
    logic                 oOVERFLOW;
    logic                 oUNDERFLOW;

    modport master (
        output iCTRL_HOLD, iFLAG, iFLAG_NEXT, iFLAG_NEXT_VALID,
               iSAVE_REQ, iRESTORE_REQ, iFLAGR_BUSY,
        input  oRESTORE_READY, oPFLAGR, oPFLAGR_VALID, oDEPTH, oOVERFLOW, oUNDERFLOW
    );

    modport slave (
        input  iCTRL_HOLD, iFLAG, iFLAG_NEXT, iFLAG_NEXT_VALID,
               iSAVE_REQ, iRESTORE_REQ, iFLAGR_BUSY,
        output oRESTORE_READY, oPFLAGR, oPFLAGR_VALID, oDEPTH, oOVERFLOW, oUNDERFLOW
    );

endinterface

// File: rtl/execute_flag_shadow_stack_lifo.sv
// Parameterised flag-word LIFO with push, pop and simultaneous replace-top.
// The caller gates push/pop; a push while full without a pop is ignored here.
module execute_flag_lifo
    import execute_flag_pkg::*;
#(
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_W = $clog2(P_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 srst,
    input  logic                 push,
    input  logic                 pop,
    input  flag_t                wdata,
    output flag_t                rdata,
    output logic                 full,
    output logic                 empty,
    output logic [P_DEPTH_W-1:0] count
);

    localparam int IDX_W = P_DEPTH_W - 1;

    flag_t                mem_q [P_DEPTH];
    flag_t                mem_d [P_DEPTH];
    logic [P_DEPTH_W-1:0] count_q;
    logic [P_DEPTH_W-1:0] count_d;
    logic [IDX_W-1:0]     top_idx_s;
    logic [IDX_W-1:0]     wr_idx_s;
    logic [P_DEPTH_W-1:0] top_cnt_s;

    assign top_cnt_s = count_q - {{(P_DEPTH_W-1){1'b0}}, 1'b1};
    assign top_idx_s = top_cnt_s[IDX_W-1:0];
    assign wr_idx_s  = count_q[IDX_W-1:0];
    assign full      = (count_q == P_DEPTH_W'(P_DEPTH));
    assign empty     = (count_q == {P_DEPTH_W{1'b0}});
    assign rdata     = mem_q[top_idx_s];
    assign count     = count_q;

    // Next-state: replace-top on push+pop keeps depth, otherwise plain push or pop.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (srst) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                mem_d[i] = FLAG_RESET;
            end
            count_d = {P_DEPTH_W{1'b0}};
        end else if (push && pop && !empty) begin
            mem_d[top_idx_s] = wdata;
        end else if (push && !full) begin
            mem_d[wr_idx_s] = wdata;
            count_d         = count_q + {{(P_DEPTH_W-1){1'b0}}, 1'b1};
        end else if (pop && !empty) begin
            count_d = top_cnt_s;
        end else begin
            count_d = count_q;
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                mem_q[i] <= FLAG_RESET;
            end
            count_q <= {P_DEPTH_W{1'b0}};
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/execute_flag_shadow_stack.sv
// Execute-stage flag shadow stack: saves flags on trap entry and drives the
// restored word with a one-cycle strobe into the flag register on return.
module execute_flag_shadow_stack
    import execute_flag_pkg::*;
#(
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_W = $clog2(P_DEPTH) + 1
) (
    input  logic                          iCLOCK,
    input  logic                          inRESET,
    input  logic                          iRESET_SYNC,
    execute_flag_shadow_stack_if.slave    bus
);

    fsm_state_t           state_q, state_d;
    flag_t                pflagr_q, pflagr_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    flag_t                save_val_s;
    flag_t                top_s;
    logic                 full_s, empty_s;
    logic [P_DEPTH_W-1:0] depth_s;
    logic                 active_s, restore_try_s, pop_s, push_s;

    assign save_val_s    = flag_select(bus.iFLAG, bus.iFLAG_NEXT, bus.iFLAG_NEXT_VALID);
    assign active_s      = !bus.iCTRL_HOLD && !iRESET_SYNC;
    assign restore_try_s = active_s && bus.iRESTORE_REQ && (state_q == IDLE);
    assign pop_s         = restore_try_s && !empty_s;
    // A pop frees the top slot in the same cycle, so a save while full becomes a replace.
    assign push_s        = active_s && bus.iSAVE_REQ && (!full_s || pop_s);

    execute_flag_lifo #(
        .P_DEPTH   (P_DEPTH),
        .P_DEPTH_W (P_DEPTH_W)
    ) u_lifo (
        .clk   (iCLOCK),
        .rst_n (inRESET),
        .srst  (iRESET_SYNC),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (save_val_s),
        .rdata (top_s),
        .full  (full_s),
        .empty (empty_s),
        .count (depth_s)
    );

    // Restore FSM, output holding register, strobe and sticky error next-state.
    always_comb begin
        state_d  = state_q;
        pflagr_d = pflagr_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q || (active_s && bus.iSAVE_REQ && full_s && !pop_s);
        unf_d    = unf_q || (restore_try_s && empty_s);
        if (iRESET_SYNC) begin
            state_d  = IDLE;
            pflagr_d = FLAG_RESET;
            valid_d  = 1'b0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop_s) begin
                        pflagr_d = top_s;
                        if (bus.iFLAGR_BUSY) begin
                            state_d = PEND;
                        end else begin
                            valid_d = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                PEND: begin
                    if (active_s && !bus.iFLAGR_BUSY) begin
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = PEND;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Single register stage for FSM and all registered outputs.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q  <= IDLE;
            pflagr_q <= FLAG_RESET;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pflagr_q <= pflagr_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign bus.oRESTORE_READY = (state_q == IDLE);
    assign bus.oPFLAGR        = pflagr_q;
    assign bus.oPFLAGR_VALID  = valid_q;
    assign bus.oDEPTH         = depth_s;
    assign bus.oOVERFLOW      = ovf_q;
    assign bus.oUNDERFLOW     = unf_q;

endmodule

// File: tb/tb_execute_flag_shadow_stack.sv
// Directed self-checking bench for execute_flag_shadow_stack (P_DEPTH=4).
module tb_execute_flag_shadow_stack;

    logic clk;
    logic rst_n;
    logic srst;
    int   checks;
    int   errors;

    execute_flag_shadow_stack_if #(.P_DEPTH(4)) bus ();

    execute_flag_shadow_stack #(.P_DEPTH(4)) dut (
        .iCLOCK      (clk),
        .inRESET     (rst_n),
        .iRESET_SYNC (srst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iCTRL_HOLD       = 1'b0;
        bus.iFLAG            = 5'h00;
        bus.iFLAG_NEXT       = 5'h00;
        bus.iFLAG_NEXT_VALID = 1'b0;
        bus.iSAVE_REQ        = 1'b0;
        bus.iRESTORE_REQ     = 1'b0;
        bus.iFLAGR_BUSY      = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        srst  = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (bus.oDEPTH !== 3'd0) begin errors++; $display("FAIL reset_depth got %h want 0", bus.oDEPTH); end
        checks++; if (bus.oPFLAGR !== 5'h00) begin errors++; $display("FAIL reset_pflagr got %h want 00", bus.oPFLAGR); end
        checks++; if (bus.oPFLAGR_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.oPFLAGR_VALID); end
        checks++; if (bus.oRESTORE_READY !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.oRESTORE_READY); end
        checks++; if ({bus.oOVERFLOW, bus.oUNDERFLOW} !== 2'b00) begin errors++; $display("FAIL reset_sticky got %b want 00", {bus.oOVERFLOW, bus.oUNDERFLOW}); end
    endtask

    task automatic test_push_pop();
        bus.iFLAG = 5'h15; bus.iSAVE_REQ = 1'b1;
        tick();
        bus.iSAVE_REQ = 1'b0;
        checks++; if (bus.oDEPTH !== 3'd1) begin errors++; $display("FAIL pp_depth_push got %h want 1", bus.oDEPTH); end
        checks++; if (bus.oPFLAGR_VALID !== 1'b0) begin errors++; $display("FAIL pp_no_early_strobe got %b want 0", bus.oPFLAGR_VALID); end
        bus.iRESTORE_REQ = 1'b1;
        tick();
        bus.iRESTORE_REQ = 1'b0;
        checks++; if (bus.oPFLAGR_VALID !== 1'b1) begin errors++; $display("FAIL pp_valid got %b want 1", bus.oPFLAGR_VALID); end
        checks++; if (bus.oPFLAGR !== 5'h15) begin errors++; $display("FAIL pp_value got %h want 15", bus.oPFLAGR); end
        checks++; if (bus.oDEPTH !== 3'd0) begin errors++; $display("FAIL pp_depth_pop got %h want 0", bus.oDEPTH); end
        tick();
        checks++; if (bus.oPFLAGR_VALID !== 1'b0) begin errors++; $display("FAIL pp_one_cycle got %b want 0", bus.oPFLAGR_VALID); end
        checks++; if (bus.oPFLAGR !== 5'h15) begin errors++; $display("FAIL pp_hold_value got %h want 15", bus.oPFLAGR); end
    endtask

    task automatic test_bypass();
        bus.iFLAG = 5'h1F; bus.iFLAG_NEXT = 5'h0A; bus.iFLAG_NEXT_VALID = 1'b1; bus.iSAVE_REQ = 1'b1;
        tick();
        idle_inputs();
        bus.iFLAG = 5'h1F;
        bus.iRESTORE_REQ = 1'b1;
        tick();
        bus.iRESTORE_REQ = 1'b0;
        checks++; if (bus.oPFLAGR !== 5'h0A) begin errors++; $display("FAIL bypass_value got %h want 0a", bus.oPFLAGR); end
        checks++; if (bus.oPFLAGR_VALID !== 1'b1) begin errors++; $display("FAIL bypass_valid got %b want 1", bus.oPFLAGR_VALID); end
        tick();
    endtask

    task automatic test_busy_stall();
        bus.iFLAG = 5'h07; bus.iSAVE_REQ = 1'b1;
        tick();
        bus.iSAVE_REQ = 1'b0;
        bus.iFLAGR_BUSY = 1'b1; bus.iRESTORE_REQ = 1'b1;
        tick();
        bus.iRESTORE_REQ = 1'b0;
        checks++; if (bus.oRESTORE_READY !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", bus.oRESTORE_READY); end
        checks++; if (bus.oPFLAGR_VALID !== 1'b0) begin errors++; $display("FAIL busy_valid1 got %b want 0", bus.oPFLAGR_VALID); end
        checks++; if (bus.oDEPTH !== 3'd0) begin errors++; $display("FAIL busy_depth_pop got %h want 0", bus.oDEPTH); end
        bus.iFLAG = 5'h11; bus.iSAVE_REQ = 1'b1; bus.iRESTORE_REQ = 1'b1;
        tick();
        bus.iSAVE_REQ = 1'b0; bus.iRESTORE_REQ = 1'b0;
        checks++; if (bus.oDEPTH !== 3'd1) begin errors++; $display("FAIL busy_save_depth got %h want 1", bus.oDEPTH); end
        checks++; if (bus.oRESTORE_READY !== 1'b0) begin errors++; $display("FAIL busy_ready2 got %b want 0", bus.oRESTORE_READY); end
        tick();
        checks++; if (bus.oPFLAGR_VALID !== 1'b0) begin errors++; $display("FAIL busy_valid3 got %b want 0", bus.oPFLAGR_VALID); end
        bus.iFLAGR_BUSY = 1'b0;
        tick();
        checks++; if (bus.oPFLAGR_VALID !== 1'b1) begin errors++; $display("FAIL busy_strobe got %b want 1", bus.oPFLAGR_VALID); end
        checks++; if (bus.oPFLAGR !== 5'h07) begin errors++; $display("FAIL busy_value got %h want 07", bus.oPFLAGR); end
        checks++; if (bus.oRESTORE_READY !== 1'b1) begin errors++; $display("FAIL busy_ready_back got %b want 1", bus.oRESTORE_READY); end
        bus.iRESTORE_REQ = 1'b1;
        tick();
        bus.iRESTORE_REQ = 1'b0;
        checks++; if (bus.oPFLAGR !== 5'h11) begin errors++; $display("FAIL busy_drain got %h want 11", bus.oPFLAGR); end
        checks++; if (bus.oDEPTH !== 3'd0) begin errors++; $display("FAIL busy_drain_depth got %h want 0", bus.oDEPTH); end
        tick();
    endtask

    task automatic test_overflow_underflow();
        logic [4:0] exp_vals [4];
        exp_vals = '{5'h04, 5'h03, 5'h02, 5'h01};
        for (int i = 1; i <= 5; i++) begin
            bus.iFLAG = 5'(i); bus.iSAVE_REQ = 1'b1;
            tick();
        end
        bus.iSAVE_REQ = 1'b0;
        checks++; if (bus.oDEPTH !== 3'd4) begin errors++; $display("FAIL ovf_depth got %h want 4", bus.oDEPTH); end
        checks++; if (bus.oOVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", bus.oOVERFLOW); end
        bus.iRESTORE_REQ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({bus.oPFLAGR_VALID, bus.oPFLAGR} !== {1'b1, exp_vals[i]}) begin errors++; $display("FAIL lifo_order%0d got %b/%h want 1/%h", i, bus.oPFLAGR_VALID, bus.oPFLAGR, exp_vals[i]); end
        end
        tick();
        bus.iRESTORE_REQ = 1'b0;
        checks++; if (bus.oPFLAGR_VALID !== 1'b0) begin errors++; $display("FAIL unf_no_strobe got %b want 0", bus.oPFLAGR_VALID); end
        checks++; if (bus.oUNDERFLOW !== 1'b1) begin errors++; $display("FAIL unf_flag got %b want 1", bus.oUNDERFLOW); end
        checks++; if (bus.oPFLAGR !== 5'h01) begin errors++; $display("FAIL unf_hold got %h want 01", bus.oPFLAGR); end
        tick();
        checks++; if ({bus.oOVERFLOW, bus.oUNDERFLOW} !== 2'b11) begin errors++; $display("FAIL sticky_keep got %b want 11", {bus.oOVERFLOW, bus.oUNDERFLOW}); end
    endtask

    task automatic test_simultaneous();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        checks++; if ({bus.oOVERFLOW, bus.oUNDERFLOW} !== 2'b00) begin errors++; $display("FAIL srst_sticky got %b want 00", {bus.oOVERFLOW, bus.oUNDERFLOW}); end
        checks++; if (bus.oPFLAGR !== 5'h00) begin errors++; $display("FAIL srst_pflagr got %h want 00", bus.oPFLAGR); end
        bus.iSAVE_REQ = 1'b1;
        bus.iFLAG = 5'h09; tick();
        bus.iFLAG = 5'h03; tick();
        bus.iFLAG = 5'h1C; bus.iRESTORE_REQ = 1'b1;
        tick();
        bus.iSAVE_REQ = 1'b0;
        checks++; if (bus.oPFLAGR !== 5'h03) begin errors++; $display("FAIL simul_old_top got %h want 03", bus.oPFLAGR); end
        checks++; if (bus.oDEPTH !== 3'd2) begin errors++; $display("FAIL simul_depth got %h want 2", bus.oDEPTH); end
        tick();
        checks++; if (bus.oPFLAGR !== 5'h1C) begin errors++; $display("FAIL simul_new_top got %h want 1c", bus.oPFLAGR); end
        tick();
        checks++; if (bus.oPFLAGR !== 5'h09) begin errors++; $display("FAIL simul_bottom got %h want 09", bus.oPFLAGR); end
        checks++; if (bus.oUNDERFLOW !== 1'b0) begin errors++; $display("FAIL simul_no_unf got %b want 0", bus.oUNDERFLOW); end
        bus.iFLAG = 5'h12; bus.iSAVE_REQ = 1'b1;
        tick();
        bus.iSAVE_REQ = 1'b0; bus.iRESTORE_REQ = 1'b0;
        checks++; if ({bus.oDEPTH, bus.oUNDERFLOW, bus.oPFLAGR_VALID} !== {3'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL simul_empty got %h/%b/%b want 1/1/0", bus.oDEPTH, bus.oUNDERFLOW, bus.oPFLAGR_VALID); end
        bus.iRESTORE_REQ = 1'b1;
        tick();
        bus.iRESTORE_REQ = 1'b0;
        checks++; if (bus.oPFLAGR !== 5'h12) begin errors++; $display("FAIL simul_empty_saved got %h want 12", bus.oPFLAGR); end
        tick();
    endtask

    task automatic test_hold();
        bus.iFLAG = 5'h06; bus.iSAVE_REQ = 1'b1;
        tick();
        bus.iCTRL_HOLD = 1'b1; bus.iFLAG = 5'h0F; bus.iRESTORE_REQ = 1'b1;
        tick();
        checks++; if ({bus.oDEPTH, bus.oPFLAGR_VALID, bus.oPFLAGR} !== {3'd1, 1'b0, 5'h12}) begin errors++; $display("FAIL hold_frozen got %h/%b/%h want 1/0/12", bus.oDEPTH, bus.oPFLAGR_VALID, bus.oPFLAGR); end
        bus.iCTRL_HOLD = 1'b0; bus.iSAVE_REQ = 1'b0;
        tick();
        bus.iRESTORE_REQ = 1'b0;
        checks++; if ({bus.oPFLAGR_VALID, bus.oPFLAGR} !== {1'b1, 5'h06}) begin errors++; $display("FAIL hold_release got %b/%h want 1/06", bus.oPFLAGR_VALID, bus.oPFLAGR); end
        bus.iFLAG = 5'h0B; bus.iSAVE_REQ = 1'b1;
        tick();
        bus.iSAVE_REQ = 1'b0; bus.iFLAGR_BUSY = 1'b1; bus.iRESTORE_REQ = 1'b1;
        tick();
        bus.iRESTORE_REQ = 1'b0; bus.iFLAGR_BUSY = 1'b0; bus.iCTRL_HOLD = 1'b1;
        tick();
        checks++; if ({bus.oPFLAGR_VALID, bus.oRESTORE_READY} !== 2'b00) begin errors++; $display("FAIL hold_pend_defer got %b want 00", {bus.oPFLAGR_VALID, bus.oRESTORE_READY}); end
        bus.iCTRL_HOLD = 1'b0;
        tick();
        checks++; if ({bus.oPFLAGR_VALID, bus.oPFLAGR} !== {1'b1, 5'h0B}) begin errors++; $display("FAIL hold_pend_strobe got %b/%h want 1/0b", bus.oPFLAGR_VALID, bus.oPFLAGR); end
        tick();
    endtask

    task automatic test_reset_in_pend();
        bus.iFLAG = 5'h19; bus.iSAVE_REQ = 1'b1;
        tick();
        bus.iSAVE_REQ = 1'b0; bus.iFLAGR_BUSY = 1'b1; bus.iRESTORE_REQ = 1'b1;
        tick();
        bus.iRESTORE_REQ = 1'b0;
        checks++; if (bus.oRESTORE_READY !== 1'b0) begin errors++; $display("FAIL rstp_in_pend got %b want 0", bus.oRESTORE_READY); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({bus.oRESTORE_READY, bus.oPFLAGR_VALID, bus.oPFLAGR, bus.oDEPTH} !== {1'b1, 1'b0, 5'h00, 3'd0}) begin errors++; $display("FAIL rstp_async got %b/%b/%h/%h want 1/0/00/0", bus.oRESTORE_READY, bus.oPFLAGR_VALID, bus.oPFLAGR, bus.oDEPTH); end
        bus.iFLAGR_BUSY = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({bus.oPFLAGR_VALID, bus.oRESTORE_READY, bus.oPFLAGR} !== {1'b0, 1'b1, 5'h00}) begin errors++; $display("FAIL rstp_no_strobe%0d got %b/%b/%h want 0/1/00", i, bus.oPFLAGR_VALID, bus.oRESTORE_READY, bus.oPFLAGR); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_push_pop();
        test_bypass();
        test_busy_stall();
        test_overflow_underflow();
        test_simultaneous();
        test_hold();
        test_reset_in_pend();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
